// File: rtl/cp0_regfile_p.sv
// cp0_regfile_p: MIPS CP0 register file with exception entry, ERET and interrupt request.
// Define CP0_TIMER_EN to build the prescaled Count/Compare timer; otherwise Count/Compare read 0.
module cp0_regfile_p #(
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] PRID_VAL   = 32'h004C0102,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  we,
   input  logic [4:0]            waddr,
   input  logic [31:0]           wdata,
   input  logic [4:0]            raddr,
   output logic [31:0]           rdata,
   input  logic [HW_INT_NUM-1:0] int_i,
   input  logic                  excpt_valid,
   input  logic [4:0]            excpt_code,
   input  logic [31:0]           excpt_pc,
   input  logic                  excpt_bd,
   input  logic [31:0]           excpt_badvaddr,
   input  logic                  eret,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o,
   output logic                  int_req_o,
   output logic                  flush_o,
   output logic [31:0]           flush_pc_o,
   output logic                  timer_int_o
);

   localparam logic [4:0]  REG_BADVADDR = 5'd8;
   localparam logic [4:0]  REG_COUNT    = 5'd9;
   localparam logic [4:0]  REG_COMPARE  = 5'd11;
   localparam logic [4:0]  REG_STATUS   = 5'd12;
   localparam logic [4:0]  REG_CAUSE    = 5'd13;
   localparam logic [4:0]  REG_EPC      = 5'd14;
   localparam logic [4:0]  REG_PRID     = 5'd15;
   localparam logic [4:0]  REG_CONFIG   = 5'd16;
   localparam logic [31:0] CONFIG_VAL   = 32'h00008000;

   logic        upd_s;
   logic        exc_s;
   logic        eret_s;
   logic        wr_status_s;
   logic        wr_cause_s;
   logic        wr_epc_s;
   logic [5:0]  int_pad_s;
   logic [5:0]  ip_hw_next_s;
   logic [31:0] count_s;
   logic [31:0] compare_s;
   logic        timer_int_s;

   logic [7:0]  im_r;
   logic        exl_r;
   logic        ie_r;
   logic [5:0]  ip_hw_r;
   logic [1:0]  ip_sw_r;
   logic        bd_r;
   logic [4:0]  exc_code_r;
   logic [31:0] epc_r;
   logic [31:0] badvaddr_r;
   logic        int_req_r;

   assign upd_s       = ~stall;
   assign exc_s       = upd_s & excpt_valid;
   assign eret_s      = upd_s & eret;
   assign wr_status_s = upd_s & we & (waddr == REG_STATUS);
   assign wr_cause_s  = upd_s & we & (waddr == REG_CAUSE);
   assign wr_epc_s    = upd_s & we & (waddr == REG_EPC);

   // Zero-extend the hardware lines into the six IP[15:10] slots; the timer shares IP[15].
   always_comb begin
      int_pad_s                  = 6'b0;
      int_pad_s[HW_INT_NUM-1:0]  = int_i;
      ip_hw_next_s               = {timer_int_s | int_pad_s[5], int_pad_s[4:0]};
   end

`ifdef CP0_TIMER_EN
   localparam int               DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0] div_r;
   logic [31:0]      count_r;
   logic [31:0]      compare_r;
   logic             timer_int_r;
   logic             wr_count_s;
   logic             wr_compare_s;

   assign wr_count_s   = upd_s & we & (waddr == REG_COUNT);
   assign wr_compare_s = upd_s & we & (waddr == REG_COMPARE);

   // Prescaled Count, Compare and the sticky timer flag (a Compare write wins over a match).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_r       <= '0;
         count_r     <= 32'h0;
         compare_r   <= 32'h0;
         timer_int_r <= 1'b0;
      end else if (upd_s) begin
         if (wr_count_s) begin
            count_r <= wdata;
            div_r   <= '0;
         end else if (div_r == DIV_LAST) begin
            count_r <= count_r + 32'd1;
            div_r   <= '0;
         end else begin
            div_r   <= div_r + DIV_W'(1);
         end
         if (wr_compare_s) begin
            compare_r   <= wdata;
            timer_int_r <= 1'b0;
         end else if ((compare_r != 32'h0) && (count_r == compare_r)) begin
            timer_int_r <= 1'b1;
         end
      end
   end

   assign count_s     = count_r;
   assign compare_s   = compare_r;
   assign timer_int_s = timer_int_r;
`else
   assign count_s     = 32'h0;
   assign compare_s   = 32'h0;
   assign timer_int_s = 1'b0;
`endif

   // Status/Cause/EPC/BadVAddr state: exception beats ERET beats MTC0 on shared fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         im_r       <= 8'h0;
         exl_r      <= 1'b0;
         ie_r       <= 1'b0;
         ip_hw_r    <= 6'b0;
         ip_sw_r    <= 2'b0;
         bd_r       <= 1'b0;
         exc_code_r <= 5'd0;
         epc_r      <= 32'h0;
         badvaddr_r <= 32'h0;
         int_req_r  <= 1'b0;
      end else if (upd_s) begin
         ip_hw_r   <= ip_hw_next_s;
         int_req_r <= ie_r & ~exl_r & (|({ip_hw_r, ip_sw_r} & im_r));
         if (exc_s) begin
            exl_r <= 1'b1;
         end else if (eret_s) begin
            exl_r <= 1'b0;
         end else if (wr_status_s) begin
            exl_r <= wdata[1];
         end
         if (wr_status_s) begin
            im_r <= wdata[15:8];
            ie_r <= wdata[0];
         end
         if (wr_cause_s) begin
            ip_sw_r <= wdata[9:8];
         end
         if (exc_s) begin
            exc_code_r <= excpt_code;
         end
         // A nested exception (EXL already set) must keep the original return point.
         if (exc_s && !exl_r) begin
            epc_r <= excpt_bd ? (excpt_pc - 32'd4) : excpt_pc;
            bd_r  <= excpt_bd;
         end else if (wr_epc_s) begin
            epc_r <= wdata;
         end
         if (exc_s && ((excpt_code == 5'd4) || (excpt_code == 5'd5))) begin
            badvaddr_r <= excpt_badvaddr;
         end
      end
   end

   assign status_o    = {9'b0, 1'b1, 6'b0, im_r, 6'b0, exl_r, ie_r};
   assign cause_o     = {bd_r, timer_int_s, 14'b0, ip_hw_r, ip_sw_r, 1'b0, exc_code_r, 2'b0};
   assign epc_o       = epc_r;
   assign int_req_o   = int_req_r;
   assign timer_int_o = timer_int_s;
   assign flush_o     = upd_s & (excpt_valid | eret);
   assign flush_pc_o  = excpt_valid ? EXC_VECTOR : epc_r;

   // MFC0 read mux.
   always_comb begin
      case (raddr)
         REG_BADVADDR: rdata = badvaddr_r;
         REG_COUNT:    rdata = count_s;
         REG_COMPARE:  rdata = compare_s;
         REG_STATUS:   rdata = status_o;
         REG_CAUSE:    rdata = cause_o;
         REG_EPC:      rdata = epc_r;
         REG_PRID:     rdata = PRID_VAL;
         REG_CONFIG:   rdata = CONFIG_VAL;
         default:      rdata = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0_regfile_p.sv
// Scoreboard bench for cp0_regfile_p: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live DUT outputs.
`timescale 1ns/1ps
module tb_cp0_regfile_p;
`ifdef CP0_TIMER_EN
   localparam bit TMR = 1'b1;
`else
   localparam bit TMR = 1'b0;
`endif

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, we, excpt_valid, excpt_bd, eret;
   logic [4:0]  waddr, raddr, excpt_code;
   logic [31:0] wdata, excpt_pc, excpt_badvaddr, rdata;
   logic [5:0]  int_i;
   logic [31:0] status_o, cause_o, epc_o, flush_pc_o;
   logic        int_req_o, flush_o, timer_int_o;

   logic        we2;
   logic [4:0]  waddr2, raddr2;
   logic [31:0] wdata2, rdata2;
   logic [31:0] st2, ca2, ep2, fp2;
   logic        ir2, fl2, ti2;
   logic        zero1 = 1'b0;
   logic [4:0]  zero5 = 5'd0;
   logic [5:0]  zero6 = 6'd0;
   logic [31:0] zero32 = 32'h0;

   cp0_regfile_p dut (
      .clk(clk), .rst(rst), .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .int_i(int_i), .excpt_valid(excpt_valid),
      .excpt_code(excpt_code), .excpt_pc(excpt_pc), .excpt_bd(excpt_bd),
      .excpt_badvaddr(excpt_badvaddr), .eret(eret), .status_o(status_o),
      .cause_o(cause_o), .epc_o(epc_o), .int_req_o(int_req_o), .flush_o(flush_o),
      .flush_pc_o(flush_pc_o), .timer_int_o(timer_int_o)
   );

   cp0_regfile_p #(.COUNT_DIV(1)) dut_div1 (
      .clk(clk), .rst(rst), .stall(zero1), .we(we2), .waddr(waddr2), .wdata(wdata2),
      .raddr(raddr2), .rdata(rdata2), .int_i(zero6), .excpt_valid(zero1),
      .excpt_code(zero5), .excpt_pc(zero32), .excpt_bd(zero1),
      .excpt_badvaddr(zero32), .eret(zero1), .status_o(st2),
      .cause_o(ca2), .epc_o(ep2), .int_req_o(ir2), .flush_o(fl2),
      .flush_pc_o(fp2), .timer_int_o(ti2)
   );

   localparam int S_RDATA = 0, S_STATUS = 1, S_CAUSE = 2, S_EPC = 3, S_INTREQ = 4;
   localparam int S_FLUSH = 5, S_FLUSHPC = 6, S_TIMER = 7, S_RDATA2 = 8;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic exp_val(input string name, input int sel, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      sb_q.push_back(c);
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_RDATA:   return rdata;
         S_STATUS:  return status_o;
         S_CAUSE:   return cause_o;
         S_EPC:     return epc_o;
         S_INTREQ:  return {31'b0, int_req_o};
         S_FLUSH:   return {31'b0, flush_o};
         S_FLUSHPC: return flush_pc_o;
         S_TIMER:   return {31'b0, timer_int_o};
         S_RDATA2:  return rdata2;
         default:   return 32'hDEADDEAD;
      endcase
   endfunction

   // Monitor: compare every queued expectation against the DUT mid-cycle.
   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] act;
      while (sb_q.size() > 0) begin
         c   = sb_q.pop_front();
         act = observe(c.sel);
         n_checks++;
         if (act !== c.exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
         end
      end
   end

   initial begin
      rst = 1'b0; stall = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr = 5'd15;
      int_i = 6'd0; excpt_valid = 1'b0; excpt_code = 5'd0; excpt_pc = 32'h0;
      excpt_bd = 1'b0; excpt_badvaddr = 32'h0; eret = 1'b0;
      we2 = 1'b0; waddr2 = 5'd9; wdata2 = 32'h0; raddr2 = 5'd9;

      exp_val("rst_status", S_STATUS, 32'h00400000);
      exp_val("rst_cause", S_CAUSE, 32'h0);
      exp_val("rst_epc", S_EPC, 32'h0);
      exp_val("rst_intreq", S_INTREQ, 32'h0);
      exp_val("rst_timer", S_TIMER, 32'h0);
      exp_val("prid", S_RDATA, 32'h004C0102);
      cyc();

      // Eight unstalled cycles after release at COUNT_DIV=2.
      rst = 1'b1;
      repeat (7) cyc();
      raddr = 5'd9;
      exp_val("count_after_8", S_RDATA, TMR ? 32'd4 : 32'd0);
      exp_val("status_idle", S_STATUS, 32'h00400000);
      cyc();

`ifdef CP0_TIMER_EN
      we = 1'b1; waddr = 5'd11; wdata = 32'd6; cyc();
      waddr = 5'd9; wdata = 32'd3; cyc();
      waddr = 5'd12; wdata = 32'h00008001; cyc();
      we = 1'b0;
      repeat (4) cyc();
      exp_val("timer_before_match", S_TIMER, 32'h0);
      cyc();
      exp_val("timer_at_match", S_TIMER, 32'h1);
      exp_val("cause_ti_only", S_CAUSE, 32'h40000000);
      cyc();
      exp_val("cause_ip15", S_CAUSE, 32'h40008000);
      exp_val("intreq_not_yet", S_INTREQ, 32'h0);
      cyc();
      exp_val("intreq_timer", S_INTREQ, 32'h1);
      cyc();
      we = 1'b1; waddr = 5'd11; wdata = 32'h00000100;
      exp_val("timer_cleared", S_TIMER, 32'h0);
      cyc();
      waddr = 5'd12; wdata = 32'h0; cyc();
`else
      we = 1'b1; waddr = 5'd9; wdata = 32'h00001234; raddr = 5'd9;
      exp_val("count_absent", S_RDATA, 32'h0);
      exp_val("timer_absent", S_TIMER, 32'h0);
      cyc();
      waddr = 5'd11; wdata = 32'd5; raddr = 5'd11;
      exp_val("compare_absent", S_RDATA, 32'h0);
      cyc();
`endif

      // Hardware interrupt on int_i[1] -> IP[11], unmasked by IM[3].
      we = 1'b1; waddr = 5'd12; wdata = 32'h00000801; int_i = 6'b000010;
      exp_val("cause_ip11", S_CAUSE, 32'h00000800);
      exp_val("status_im3", S_STATUS, 32'h00400801);
      exp_val("intreq_pre", S_INTREQ, 32'h0);
      cyc();
      we = 1'b0;
      exp_val("intreq_hw", S_INTREQ, 32'h1);
      cyc();
      we = 1'b1; waddr = 5'd12; wdata = 32'h0; int_i = 6'd0;
      exp_val("cause_ip_clear", S_CAUSE, 32'h0);
      cyc();
      we = 1'b0;
      exp_val("intreq_drop", S_INTREQ, 32'h0);
      cyc();

      // MTC0 field masks and non-writable registers.
      we = 1'b1; waddr = 5'd13; wdata = 32'hFFFFFFFF;
      exp_val("cause_sw_ip", S_CAUSE, 32'h00000300);
      cyc();
      waddr = 5'd14; wdata = 32'h12345678;
      exp_val("epc_write", S_EPC, 32'h12345678);
      cyc();
      waddr = 5'd8; wdata = 32'hDEADBEEF; raddr = 5'd8;
      exp_val("badvaddr_ro", S_RDATA, 32'h0);
      cyc();
      waddr = 5'd13; wdata = 32'h0; raddr = 5'd16;
      exp_val("config", S_RDATA, 32'h00008000);
      cyc();
      we = 1'b0; raddr = 5'd20;
      exp_val("unmapped", S_RDATA, 32'h0);
      cyc();

      // AdES in a delay slot.
      excpt_valid = 1'b1; excpt_code = 5'd5; excpt_pc = 32'hBFC01004; excpt_bd = 1'b1;
      excpt_badvaddr = 32'h3; raddr = 5'd8;
      exp_val("exc_flush", S_FLUSH, 32'h1);
      exp_val("exc_flush_pc", S_FLUSHPC, 32'hBFC00380);
      exp_val("exc_epc", S_EPC, 32'hBFC01000);
      exp_val("exc_cause", S_CAUSE, 32'h80000014);
      exp_val("exc_status", S_STATUS, 32'h00400002);
      exp_val("exc_badvaddr", S_RDATA, 32'h3);
      cyc();

      // Nested Sys while EXL=1.
      excpt_code = 5'd8; excpt_pc = 32'h00000100; excpt_bd = 1'b0; excpt_badvaddr = 32'h55;
      exp_val("nest_epc", S_EPC, 32'hBFC01000);
      exp_val("nest_cause", S_CAUSE, 32'h80000020);
      exp_val("nest_badvaddr", S_RDATA, 32'h3);
      cyc();

      excpt_valid = 1'b0; eret = 1'b1;
      exp_val("eret_flush", S_FLUSH, 32'h1);
      exp_val("eret_flush_pc", S_FLUSHPC, 32'hBFC01000);
      exp_val("eret_status", S_STATUS, 32'h00400000);
      cyc();
      eret = 1'b0; we = 1'b1; waddr = 5'd12; wdata = 32'h00000001;
      exp_val("ie_set", S_STATUS, 32'h00400001);
      cyc();

      // Exception, ERET and MTC0 Status together.
      excpt_valid = 1'b1; excpt_code = 5'd12; excpt_pc = 32'h00000200; eret = 1'b1;
      wdata = 32'h0;
      exp_val("combo_flush_pc", S_FLUSHPC, 32'hBFC00380);
      exp_val("combo_status", S_STATUS, 32'h00400002);
      exp_val("combo_cause", S_CAUSE, 32'h00000030);
      exp_val("combo_epc", S_EPC, 32'h00000200);
      cyc();
      excpt_valid = 1'b0; eret = 1'b0;

      // Stall freezes Count, divider, writes and exceptions.
      waddr = 5'd9; wdata = 32'h00000050; raddr = 5'd9; cyc();
      stall = 1'b1; wdata = 32'h00000099; excpt_valid = 1'b1; excpt_code = 5'd9;
      exp_val("stall_noflush", S_FLUSH, 32'h0);
      repeat (4) cyc();
      exp_val("stall_count", S_RDATA, TMR ? 32'h50 : 32'h0);
      exp_val("stall_cause", S_CAUSE, 32'h00000030);
      cyc();
      stall = 1'b0; we = 1'b0; excpt_valid = 1'b0;
      exp_val("unstall_count1", S_RDATA, TMR ? 32'h50 : 32'h0);
      cyc();
      exp_val("unstall_count2", S_RDATA, TMR ? 32'h51 : 32'h0);
      cyc();

      // Async reset while Count=FFFFFFFF, stalled so no edge could explain the clear.
      we = 1'b1; wdata = 32'hFFFFFFFF; cyc();
      we = 1'b0; stall = 1'b1;
      exp_val("count_max", S_RDATA, TMR ? 32'hFFFFFFFF : 32'h0);
      cyc();
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_val("arst_count", S_RDATA, 32'h0);
      exp_val("arst_status", S_STATUS, 32'h00400000);
      exp_val("arst_cause", S_CAUSE, 32'h0);
      exp_val("arst_epc", S_EPC, 32'h0);
      exp_val("arst_intreq", S_INTREQ, 32'h0);
      cyc();
      rst = 1'b1; stall = 1'b0;
      exp_val("post_rst_count1", S_RDATA, 32'h0);
      cyc();
      exp_val("post_rst_count2", S_RDATA, TMR ? 32'h1 : 32'h0);
      cyc();

      // COUNT_DIV=1 wrap.
      we2 = 1'b1; wdata2 = 32'hFFFFFFFF;
      exp_val("div1_preload", S_RDATA2, TMR ? 32'hFFFFFFFF : 32'h0);
      cyc();
      we2 = 1'b0;
      exp_val("div1_wrap", S_RDATA2, 32'h0);
      cyc();

      cyc();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
